seq_detect_multi: RTL

Parametrised multi-pattern serial sequence detector. Holds NUM_PAT independently programmable patterns of 1..MAX_N bits each, with a per-slot overlapping or non-overlapping match mode, and qualifies input bits with a valid strobe. It reports per-slot match pulses, a lowest-index match ID and a saturating match counter. It is the next-generation replacement for the single-pattern detector, placed between the serial input pin logic and the status/output register block.

---
 rtl/seq_det_pkg.sv | 26 ++
 rtl/seq_det_slot.sv | 61 ++++++
 rtl/seq_detect_multi.sv | 99 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the multi-pattern sequence detector.
// Slot config is sized to a fixed ceiling so the struct can live here; MAX_N must not exceed MAX_N_LIM.
package seq_det_pkg;

   localparam int MAX_N_LIM = 64;
   localparam int LEN_LIM_W = 7;

   typedef struct packed {
      logic [MAX_N_LIM-1:0] pattern;
      logic [LEN_LIM_W-1:0] len;
      logic                 nonovl;
   } slot_cfg_t;

   function automatic int len_w(input int max_n);
      return $clog2(max_n + 1);
   endfunction

   function automatic logic [MAX_N_LIM-1:0] len_mask(input logic [LEN_LIM_W-1:0] len);
      logic [MAX_N_LIM-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_N_LIM; i++)
         if (i < int'(len)) m[i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/seq_det_slot.sv
// One pattern slot: configuration registers, fresh-bit (since) counter and compare.
// o_match_next is combinational; the top registers it.
module seq_det_slot
   import seq_det_pkg::*;
#(
   parameter int MAX_N = 32,
   parameter int LEN_W = len_w(MAX_N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cfg_we,
   input  logic [MAX_N-1:0] i_cfg_pattern,
   input  logic [LEN_W-1:0] i_cfg_len,
   input  logic             i_cfg_nonovl,
   input  logic             i_flush,
   input  logic             i_bit_valid,
   input  logic [MAX_N-1:0] i_nsreg,
   output logic             o_match_next
);

   localparam logic [LEN_LIM_W-1:0] MAX_LEN = LEN_LIM_W'(MAX_N);
   localparam logic [LEN_LIM_W-1:0] ONE_L   = LEN_LIM_W'(1);
   localparam logic [LEN_W-1:0]     SINCE_MAX = LEN_W'(MAX_N);
   localparam logic [LEN_W-1:0]     ONE_S   = LEN_W'(1);

   slot_cfg_t            r_cfg;
   logic [LEN_W-1:0]     r_since;
   logic [MAX_N_LIM-1:0] w_mask;
   logic                 w_len_ok, w_bits_eq, w_fill_ok;

   assign w_mask    = len_mask(r_cfg.len);
   assign w_len_ok  = (r_cfg.len != '0) && (r_cfg.len <= MAX_LEN);
   assign w_bits_eq = ((MAX_N_LIM'(i_nsreg) ^ r_cfg.pattern) & w_mask) == '0;
   assign w_fill_ok = (LEN_LIM_W'(r_since) + ONE_L) >= r_cfg.len;

   // A slot being rewritten this cycle is judged against nothing.
   assign o_match_next = i_bit_valid && !i_flush && !i_cfg_we &&
                         w_len_ok && w_bits_eq && w_fill_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg   <= '0;
         r_since <= '0;
      end else begin
         if (i_cfg_we) begin
            r_cfg.pattern <= MAX_N_LIM'(i_cfg_pattern);
            r_cfg.len     <= LEN_LIM_W'(i_cfg_len);
            r_cfg.nonovl  <= i_cfg_nonovl;
         end
         if (i_cfg_we || i_flush)
            r_since <= '0;
         else if (i_bit_valid) begin
            if (o_match_next && r_cfg.nonovl)
               r_since <= '0;
            else if (r_since != SINCE_MAX)
               r_since <= r_since + ONE_S;
         end
      end
   end

endmodule

// File: rtl/seq_detect_multi.sv
// Multi-pattern serial sequence detector: shared history shift register, NUM_PAT slots,
// registered match pulses with lowest-index ID, and a saturating total-match counter.
module seq_detect_multi
   import seq_det_pkg::*;
#(
   parameter int MAX_N   = 32,
   parameter int NUM_PAT = 4,
   parameter int CNT_W   = 16,
   localparam int LEN_W  = len_w(MAX_N),
   localparam int SEL_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_cfg_we,
   input  logic [SEL_W-1:0]   i_cfg_sel,
   input  logic [MAX_N-1:0]   i_cfg_pattern,
   input  logic [LEN_W-1:0]   i_cfg_len,
   input  logic               i_cfg_nonovl,
   input  logic               i_flush,
   input  logic               i_cnt_clr,
   input  logic               i_bit_valid,
   input  logic               i_data_in,
   output logic [NUM_PAT-1:0] o_match,
   output logic               o_match_any,
   output logic [SEL_W-1:0]   o_match_id,
   output logic [CNT_W-1:0]   o_match_count
);

   localparam int PC_W  = $clog2(NUM_PAT + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0] SAT = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [MAX_N-1:0]   r_sreg, w_nsreg;
   logic [NUM_PAT-1:0] r_match, w_match_next;
   logic [SEL_W-1:0]   r_id, w_id;
   logic [CNT_W-1:0]   r_count;
   logic [PC_W-1:0]    w_pop;
   logic [SUM_W-1:0]   w_sum;

   assign w_nsreg = {r_sreg[MAX_N-2:0], i_data_in};

   for (genvar i = 0; i < NUM_PAT; i++) begin : g_slot
      seq_det_slot #(.MAX_N(MAX_N), .LEN_W(LEN_W)) u_slot (
         .clk           (clk),
         .rst           (rst),
         .i_cfg_we      (i_cfg_we && (i_cfg_sel == SEL_W'(i))),
         .i_cfg_pattern (i_cfg_pattern),
         .i_cfg_len     (i_cfg_len),
         .i_cfg_nonovl  (i_cfg_nonovl),
         .i_flush       (i_flush),
         .i_bit_valid   (i_bit_valid),
         .i_nsreg       (w_nsreg),
         .o_match_next  (w_match_next[i])
      );
   end

   always_comb begin
      w_id = '0;
      for (int i = NUM_PAT - 1; i >= 0; i--)
         if (w_match_next[i]) w_id = SEL_W'(i);
   end

   // The counter accumulates the pulses already on the outputs, so it trails them by a cycle.
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NUM_PAT; i++)
         w_pop = w_pop + PC_W'(r_match[i]);
   end

   assign w_sum = SUM_W'(r_count) + SUM_W'(w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sreg  <= '0;
         r_match <= '0;
         r_id    <= '0;
         r_count <= '0;
      end else begin
         if (i_flush)
            r_sreg <= '0;
         else if (i_bit_valid)
            r_sreg <= w_nsreg;
         r_match <= w_match_next;
         r_id    <= w_id;
         if (i_cnt_clr)
            r_count <= '0;
         else if (w_sum > SAT)
            r_count <= '1;
         else
            r_count <= w_sum[CNT_W-1:0];
      end
   end

   assign o_match       = r_match;
   assign o_match_any   = |r_match;
   assign o_match_id    = r_id;
   assign o_match_count = r_count;

endmodule
